// File: rtl/rx_block_buffer.sv
// Packs UART bytes into 128-bit blocks and queues them in a first-word-fall-through FIFO.
// A partial block is dropped when the gap between its bytes exceeds TIMEOUT_CYCLES.
module rx_block_buffer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    input  logic                   rx_read,
    output logic [127:0]           pt,
    output logic                   rx_empty,
    output logic                   rx_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   frame_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t         state, state_next;
    logic [3:0]     byte_cnt, byte_cnt_next;
    logic [119:0]   shift, shift_next;
    logic [TW-1:0]  timer, timer_next;
    logic           push_req, timeout_hit;
    logic [127:0]   block;

    logic [127:0]   mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic           pop, push, drop;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        shift_next    = shift;
        timer_next    = timer;
        push_req      = 1'b0;
        timeout_hit   = 1'b0;
        block         = {shift, rx_byte};

        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    shift_next    = {shift[111:0], rx_byte};
                    byte_cnt_next = 4'd1;
                    timer_next    = '0;
                    state_next    = S_FILL;
                end
            end
            S_FILL: begin
                if (rx_valid) begin
                    timer_next = '0;
                    if (byte_cnt == 4'd15) begin
                        push_req      = 1'b1;
                        byte_cnt_next = 4'd0;
                        state_next    = S_IDLE;
                    end else begin
                        shift_next    = {shift[111:0], rx_byte};
                        byte_cnt_next = byte_cnt + 4'd1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    // The TIMEOUT_CYCLES-th consecutive idle cycle discards the partial block.
                    if (timer == T_LAST) begin
                        timeout_hit   = 1'b1;
                        byte_cnt_next = 4'd0;
                        timer_next    = '0;
                        state_next    = S_IDLE;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            byte_cnt    <= 4'd0;
            shift       <= '0;
            timer       <= '0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            byte_cnt    <= byte_cnt_next;
            shift       <= shift_next;
            timer       <= timer_next;
            frame_error <= timeout_hit;
        end
    end

    assign rx_empty = (count == '0);
    assign rx_full  = (count == CW'(DEPTH));
    assign pop      = rx_read && !rx_empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!rx_full || pop);
    assign drop     = push_req && rx_full && !pop;
    assign pt       = rx_empty ? '0 : mem[rd_ptr];

    // NOTE: block storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= block;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_block_buffer.sv
// Randomised and directed bench for rx_block_buffer against a queue-based block model.
module tb_rx_block_buffer;

    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         rx_read;
    logic [127:0] pt;
    logic         rx_empty;
    logic         rx_full;
    logic [2:0]   count;
    logic         overflow;
    logic         frame_error;

    rx_block_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_read(rx_read), .pt(pt), .rx_empty(rx_empty), .rx_full(rx_full),
        .count(count), .overflow(overflow), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int fe_seen = 0;
    bit rst_drv = 1'b0;

    // Reference model: complete blocks in arrival order, plus the bytes of the block in progress.
    logic [127:0] q[$];
    logic [7:0]   partial[$];
    int           idle_run = 0;
    bit           m_ovf = 1'b0;
    bit           m_fe = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_update(input bit v, input logic [7:0] b, input bit r, input bit rst);
        bit           full_before, do_pop, push_req;
        logic [127:0] blk;
        if (rst) begin
            q.delete(); partial.delete();
            idle_run = 0; m_ovf = 1'b0; m_fe = 1'b0;
            return;
        end
        m_fe = 1'b0;
        push_req = 1'b0;
        blk = '0;
        full_before = (q.size() == DEPTH);
        do_pop = r && (q.size() > 0);
        if (v) begin
            idle_run = 0;
            partial.push_back(b);
            if (partial.size() == 16) begin
                for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = partial[i];
                partial.delete();
                push_req = 1'b1;
            end
        end else if (partial.size() > 0) begin
            idle_run++;
            if (idle_run == TO) begin
                partial.delete();
                idle_run = 0;
                m_fe = 1'b1;
            end
        end
        if (do_pop) void'(q.pop_front());
        if (push_req) begin
            if (!full_before || do_pop) q.push_back(blk);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare();
        check("rx_empty", rx_empty, q.size() == 0);
        check("rx_full", rx_full, q.size() == DEPTH);
        check("count", count, 128'(q.size()));
        check("overflow", overflow, m_ovf);
        check("frame_error", frame_error, m_fe);
        check("pt", pt, (q.size() > 0) ? q[0] : 128'h0);
        if (frame_error === 1'b1) fe_seen++;
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit r);
        rx_valid = v; rx_byte = b; rx_read = r; reset = rst_drv;
        @(posedge clk);
        model_update(v, b, r, rst_drv);
        @(negedge clk);
        compare();
        rx_valid = 1'b0; rx_read = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_drv = 1'b1;
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0);
        rst_drv = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] base, input int nbytes, input bit read_last);
        for (int i = 0; i < nbytes; i++)
            step(1'b1, base + 8'(i), read_last && (i == nbytes - 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1'b1; rx_byte = '0; rx_valid = 1'b0; rx_read = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset(2);
        check("reset_count", count, 128'd0);
        check("reset_pt", pt, 128'h0);

        // Single block, byte order, pop
        send_block(8'h00, 16, 1'b0);
        check("t1_pt", pt, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_count", count, 128'd1);
        step(1'b0, 8'h00, 1'b1);
        check("t1_empty_after_read", rx_empty, 128'd1);

        // Overflow: five blocks, no reads
        for (int k = 1; k <= 5; k++) send_block(8'(k * 16), 16, 1'b0);
        check("t2_full", rx_full, 128'd1);
        check("t2_overflow", overflow, 128'd1);
        check("t2_count", count, 128'd4);
        check("t2_head", pt, 128'h101112131415161718191A1B1C1D1E1F);
        for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1);
        check("t2_drained", rx_empty, 128'd1);

        // Push and pop in the same cycle while full
        do_reset(1);
        for (int k = 1; k <= 4; k++) send_block(8'(k * 16), 16, 1'b0);
        send_block(8'hA0, 16, 1'b1);
        check("t3_count", count, 128'd4);
        check("t3_overflow", overflow, 128'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
        check("t3_last", pt, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        step(1'b0, 8'h00, 1'b1);

        // Timeout discards a partial block
        do_reset(1);
        fe_seen = 0;
        send_block(8'h50, 5, 1'b0);
        idle(TO + 3);
        check("t4_fe_pulses", 128'(fe_seen), 128'd1);
        check("t4_count", count, 128'd0);
        send_block(8'hF0, 16, 1'b0);
        check("t4_pt", pt, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        step(1'b0, 8'h00, 1'b1);

        // Read while empty, then reset with data queued and overflow set
        step(1'b0, 8'h00, 1'b1);
        check("t5_empty_read", count, 128'd0);
        for (int k = 1; k <= 5; k++) send_block(8'(k * 16), 16, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 8'h00, 1'b1);
        send_block(8'h70, 7, 1'b0);
        check("t5_queued", count, 128'd2);
        do_reset(1);
        check("t5_rst_empty", rx_empty, 128'd1);
        check("t5_rst_ovf", overflow, 128'd0);
        send_block(8'h30, 16, 1'b0);
        check("t5_clean", pt, 128'h303132333435363738393A3B3C3D3E3F);
        step(1'b0, 8'h00, 1'b1);

        // Random gaps and reads, many pointer wraps
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 16; i++) begin
                int gap;
                gap = (k % 17 == 16 && i == 8) ? TO + 2 : $urandom_range(0, 6);
                for (int g = 0; g < gap; g++) step(1'b0, 8'h00, $urandom_range(0, 2) == 0);
                step(1'b1, 8'($urandom), $urandom_range(0, 2) == 0);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
        check("t6_drained", rx_empty, 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
